// File: rtl/csr_pkg.sv
// Shared CSR constants and the trap sequencer state type.
package csr_pkg;

   // Machine-mode CSR addresses touched by the trap sequencer
   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;

   // mstatus bit positions
   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   // Sequencer states: one CSR write per W_* / M_* state, then one redirect
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_W_EPC    = 3'd1,
      ST_W_CAUSE  = 3'd2,
      ST_W_TVAL   = 3'd3,
      ST_W_STATUS = 3'd4,
      ST_M_STATUS = 3'd5,
      ST_REDIRECT = 3'd6
   } trap_state_e;

endpackage

// File: rtl/trap_vec_calc.sv
// Redirect-target computation: mtvec (direct or vectored) for traps,
// word-aligned mepc for MRET. Purely combinational.
module trap_vec_calc #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] mtvec_i,
   input  logic [XLEN-1:0] cause_i,
   input  logic            is_trap_i,
   input  logic [XLEN-1:0] mepc_i,
   output logic [XLEN-1:0] target_o
);

   logic [XLEN-1:0] base;
   logic [XLEN-1:0] offset;

   // Vectored mode only applies to interrupts; the add wraps modulo 2^XLEN
   always_comb begin
      base   = mtvec_i & ~XLEN'(3);
      offset = cause_i << 2;
      if (!is_trap_i) begin
         target_o = mepc_i & ~XLEN'(3);
      end else if ((mtvec_i[1:0] == 2'b01) && cause_i[XLEN-1]) begin
         target_o = base + offset;
      end else begin
         target_o = base;
      end
   end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer. Owns the CSR write port for the duration of
// a trap (mepc, mcause, mtval, mstatus) or an MRET (mstatus), then issues a
// single PC redirect. The pipeline is held from acceptance through redirect.
module trap_ctrl
   import csr_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              trap_req,
   input  logic [XLEN-1:0]   trap_cause,
   input  logic [XLEN-1:0]   trap_epc,
   input  logic [XLEN-1:0]   trap_tval,
   input  logic              mret_req,
   input  logic [XLEN-1:0]   mtvec_in,
   input  logic [XLEN-1:0]   mepc_in,
   input  logic [XLEN-1:0]   mstatus_in,
   output logic              csr_we,
   output logic [11:0]       csr_waddr,
   output logic [XLEN-1:0]   csr_wdata,
   output logic              stall,
   output logic              redirect_valid,
   output logic [XLEN-1:0]   redirect_pc,
   output trap_state_e       dbg_state
);

   trap_state_e     state_q;
   logic [XLEN-1:0] cause_q;
   logic [XLEN-1:0] epc_q;
   logic [XLEN-1:0] tval_q;
   logic            is_trap_q;
   logic            csr_we_q;
   logic [11:0]     csr_waddr_q;
   logic            redirect_q;

   logic [XLEN-1:0] status_trap;
   logic [XLEN-1:0] status_mret;
   logic [XLEN-1:0] target;

   // Handshake: a request is taken only in IDLE, on the cycle it is high;
   // requests seen in any other state are dropped, and a trap beats an MRET.
   // Sequencer FSM; write enable/address and redirect strobe are registered
   // alongside the state so they line up with the state they belong to.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         cause_q     <= '0;
         epc_q       <= '0;
         tval_q      <= '0;
         is_trap_q   <= 1'b0;
         csr_we_q    <= 1'b0;
         csr_waddr_q <= '0;
         redirect_q  <= 1'b0;
      end else begin
         csr_we_q    <= 1'b0;
         csr_waddr_q <= '0;
         redirect_q  <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (trap_req) begin
                  cause_q     <= trap_cause;
                  epc_q       <= trap_epc;
                  tval_q      <= trap_tval;
                  is_trap_q   <= 1'b1;
                  state_q     <= ST_W_EPC;
                  csr_we_q    <= 1'b1;
                  csr_waddr_q <= CSR_MEPC;
               end else if (mret_req) begin
                  is_trap_q   <= 1'b0;
                  state_q     <= ST_M_STATUS;
                  csr_we_q    <= 1'b1;
                  csr_waddr_q <= CSR_MSTATUS;
               end
            end
            ST_W_EPC: begin
               state_q     <= ST_W_CAUSE;
               csr_we_q    <= 1'b1;
               csr_waddr_q <= CSR_MCAUSE;
            end
            ST_W_CAUSE: begin
               state_q     <= ST_W_TVAL;
               csr_we_q    <= 1'b1;
               csr_waddr_q <= CSR_MTVAL;
            end
            ST_W_TVAL: begin
               state_q     <= ST_W_STATUS;
               csr_we_q    <= 1'b1;
               csr_waddr_q <= CSR_MSTATUS;
            end
            ST_W_STATUS, ST_M_STATUS: begin
               state_q    <= ST_REDIRECT;
               redirect_q <= 1'b1;
            end
            ST_REDIRECT: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // mstatus images for trap entry and MRET, built from the live mstatus_in
   always_comb begin
      status_trap = mstatus_in;
      status_trap[MSTATUS_MPIE] = mstatus_in[MSTATUS_MIE];
      status_trap[MSTATUS_MIE]  = 1'b0;
      status_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

      status_mret = mstatus_in;
      status_mret[MSTATUS_MIE]  = mstatus_in[MSTATUS_MPIE];
      status_mret[MSTATUS_MPIE] = 1'b1;
      status_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
   end

   trap_vec_calc #(.XLEN(XLEN)) u_vec (
      .mtvec_i   (mtvec_in),
      .cause_i   (cause_q),
      .is_trap_i (is_trap_q),
      .mepc_i    (mepc_in),
      .target_o  (target)
   );

   // Write data selected by the registered state; zero outside write states
   always_comb begin
      csr_wdata = '0;
      unique case (state_q)
         ST_W_EPC:    csr_wdata = epc_q & ~XLEN'(3);
         ST_W_CAUSE:  csr_wdata = cause_q;
         ST_W_TVAL:   csr_wdata = tval_q;
         ST_W_STATUS: csr_wdata = status_trap;
         ST_M_STATUS: csr_wdata = status_mret;
         default:     csr_wdata = '0;
      endcase
   end

   // Stall covers the accepting cycle combinationally; forced low in reset
   always_comb begin
      stall = reset & ((state_q != ST_IDLE) | trap_req | mret_req);
   end

   assign csr_we         = csr_we_q;
   assign csr_waddr      = csr_waddr_q;
   assign redirect_valid = redirect_q;
   assign redirect_pc    = (state_q == ST_REDIRECT) ? target : '0;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed cases from the block's test plan plus
// randomized traps/MRETs, scored against a per-cycle reference model.
module tb_trap_ctrl;
  import csr_pkg::*;

  localparam int XLEN = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic            trap_req, mret_req;
  logic [31:0]     trap_cause, trap_epc, trap_tval;
  logic [31:0]     mtvec_in, mepc_in, mstatus_in;
  logic            csr_we;
  logic [11:0]     csr_waddr;
  logic [31:0]     csr_wdata;
  logic            stall;
  logic            redirect_valid;
  logic [31:0]     redirect_pc;
  trap_state_e     dbg_state;

  trap_ctrl #(.XLEN(XLEN)) dut (
    .clk            (clk),
    .reset          (reset),
    .trap_req       (trap_req),
    .trap_cause     (trap_cause),
    .trap_epc       (trap_epc),
    .trap_tval      (trap_tval),
    .mret_req       (mret_req),
    .mtvec_in       (mtvec_in),
    .mepc_in        (mepc_in),
    .mstatus_in     (mstatus_in),
    .csr_we         (csr_we),
    .csr_waddr      (csr_waddr),
    .csr_wdata      (csr_wdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        rv;
    logic [31:0] rpc;
    logic        stall;
  } exp_t;

  logic [78:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_trap_status(input logic [31:0] m);
    return (m & ~32'h0000_1888) | (((m >> 3) & 32'd1) << 7) | 32'h0000_1800;
  endfunction

  function automatic logic [31:0] ref_mret_status(input logic [31:0] m);
    return (m & ~32'h0000_1888) | (((m >> 7) & 32'd1) << 3) | 32'h0000_0080 | 32'h0000_1800;
  endfunction

  function automatic logic [31:0] ref_trap_target(input logic [31:0] mtvec, input logic [31:0] cause);
    logic [63:0] base, t;
    base = {32'd0, mtvec} - {32'd0, mtvec % 4};
    if ((mtvec % 4 == 1) && (cause >= 32'h8000_0000))
      t = base + 64'(cause % 32'h4000_0000) * 4;
    else
      t = base;
    return t[31:0];
  endfunction

  // ---------------- drivers ----------------
  task automatic compare_cycle(input int k);
    exp_t e;
    e = exp_t'(exp_q.pop_front());
    check($sformatf("c%0d stall", k), 32'(stall), 32'(e.stall));
    check($sformatf("c%0d csr_we", k), 32'(csr_we), 32'(e.we));
    check($sformatf("c%0d csr_waddr", k), 32'(csr_waddr), 32'(e.addr));
    check($sformatf("c%0d csr_wdata", k), csr_wdata, e.wdata);
    check($sformatf("c%0d redirect_valid", k), 32'(redirect_valid), 32'(e.rv));
    check($sformatf("c%0d redirect_pc", k), redirect_pc, e.rpc);
  endtask

  // One request accepted at cycle 0; noise[k] re-pulses both requests in
  // busy cycle k; tail adds a trailing idle cycle with no request.
  task automatic do_txn(input bit is_trap, input bit is_mret,
                        input logic [31:0] cause, input logic [31:0] epc, input logic [31:0] tval,
                        input logic [31:0] f_mtvec, input logic [31:0] f_mepc, input logic [31:0] f_mstatus,
                        input bit rand_bg, input logic [7:0] noise, input bit tail);
    int n, last;
    logic [31:0] mt[8];
    logic [31:0] me[8];
    logic [31:0] ms[8];
    exp_t e;
    n = is_trap ? 6 : 3;
    last = tail ? n : n - 1;
    for (int k = 0; k <= last; k++) begin
      mt[k] = rand_bg ? $urandom : f_mtvec;
      me[k] = rand_bg ? $urandom : f_mepc;
      ms[k] = rand_bg ? $urandom : f_mstatus;
    end
    for (int k = 0; k <= last; k++) begin
      e = '0;
      e.stall = (k < n);
      if (is_trap) begin
        case (k)
          1: begin e.we = 1'b1; e.addr = 12'h341; e.wdata = epc - (epc % 4); end
          2: begin e.we = 1'b1; e.addr = 12'h342; e.wdata = cause; end
          3: begin e.we = 1'b1; e.addr = 12'h343; e.wdata = tval; end
          4: begin e.we = 1'b1; e.addr = 12'h300; e.wdata = ref_trap_status(ms[k]); end
          5: begin e.rv = 1'b1; e.rpc = ref_trap_target(mt[k], cause); end
          default: ;
        endcase
      end else begin
        case (k)
          1: begin e.we = 1'b1; e.addr = 12'h300; e.wdata = ref_mret_status(ms[k]); end
          2: begin e.rv = 1'b1; e.rpc = me[k] - (me[k] % 4); end
          default: ;
        endcase
      end
      exp_q.push_back(e);
    end
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      mtvec_in = mt[k];
      mepc_in = me[k];
      mstatus_in = ms[k];
      if (k == 0) begin
        trap_req = is_trap;
        mret_req = is_mret;
        trap_cause = cause;
        trap_epc = epc;
        trap_tval = tval;
      end else if (k < n && noise[k]) begin
        trap_req = 1'b1;
        mret_req = 1'b1;
        trap_cause = $urandom;
        trap_epc = $urandom;
        trap_tval = $urandom;
      end else begin
        trap_req = 1'b0;
        mret_req = 1'b0;
      end
      #1;
      compare_cycle(k);
    end
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    trap_req = 1'b0;
    mret_req = 1'b0;
    #1;
    check({tag, " stall"}, 32'(stall), 32'd0);
    check({tag, " csr_we"}, 32'(csr_we), 32'd0);
    check({tag, " redirect_valid"}, 32'(redirect_valid), 32'd0);
  endtask

  // Trap started, then reset pulled low while the sequencer is in W_TVAL
  task automatic reset_mid_seq();
    @(negedge clk);
    trap_req = 1'b1; mret_req = 1'b0;
    trap_cause = 32'd11; trap_epc = 32'h0000_0400; trap_tval = 32'h1234_5678;
    mtvec_in = 32'h0000_1000; mstatus_in = 32'h0000_0008;
    @(negedge clk); trap_req = 1'b0;   // W_EPC
    @(negedge clk);                    // W_CAUSE
    @(negedge clk);                    // W_TVAL
    #1;
    check("rst W_TVAL csr_waddr", 32'(csr_waddr), 32'h343);
    #1;
    reset = 1'b0;
    #1;
    check("rst csr_we", 32'(csr_we), 32'd0);
    check("rst csr_waddr", 32'(csr_waddr), 32'd0);
    check("rst csr_wdata", csr_wdata, 32'd0);
    check("rst redirect_valid", 32'(redirect_valid), 32'd0);
    check("rst redirect_pc", redirect_pc, 32'd0);
    check("rst stall", 32'(stall), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) idle_check($sformatf("post-rst c%0d", k));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b0;
    trap_req = 1'b0; mret_req = 1'b0;
    trap_cause = '0; trap_epc = '0; trap_tval = '0;
    mtvec_in = '0; mepc_in = '0; mstatus_in = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset state", 32'(dbg_state), 32'(ST_IDLE));
    check("reset csr_we", 32'(csr_we), 32'd0);
    check("reset csr_waddr", 32'(csr_waddr), 32'd0);
    check("reset csr_wdata", csr_wdata, 32'd0);
    check("reset stall", 32'(stall), 32'd0);
    check("reset redirect_valid", 32'(redirect_valid), 32'd0);
    check("reset redirect_pc", redirect_pc, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // direct-mode trap
    do_txn(1, 0, 32'd2, 32'h0000_0104, 32'hDEAD_BEEF,
           32'h0000_1000, 32'd0, 32'h0000_0008, 0, 8'h00, 1);
    // vectored interrupt
    do_txn(1, 0, 32'h8000_0007, 32'h0000_0200, 32'd0,
           32'h0000_2001, 32'd0, 32'h0000_0000, 0, 8'h00, 1);
    // vectored mtvec, synchronous exception
    do_txn(1, 0, 32'd5, 32'h0000_0203, 32'h0000_0044,
           32'h0000_2001, 32'd0, 32'h0000_0000, 0, 8'h00, 1);
    // MRET
    do_txn(0, 1, 32'd0, 32'd0, 32'd0,
           32'h0000_1000, 32'h0000_0300, 32'h0000_0080, 0, 8'h00, 1);
    // trap and MRET together, both re-pulsed during W_CAUSE
    do_txn(1, 1, 32'd3, 32'h0000_0800, 32'h0000_0ABC,
           32'h0000_3000, 32'h0000_0500, 32'h0000_0088, 0, 8'h04, 1);
    // back-to-back: MRET accepted in the cycle right after a trap redirect
    do_txn(1, 0, 32'h8000_0003, 32'h0000_0900, 32'd0,
           32'hFFFF_FFF1, 32'd0, 32'h0000_0008, 0, 8'h00, 0);
    do_txn(0, 1, 32'd0, 32'd0, 32'd0,
           32'd0, 32'h0000_0902, 32'h0000_0000, 0, 8'h00, 1);

    reset_mid_seq();

    // randomized traps / MRETs with random CSR inputs and request noise
    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = $urandom_range(0, 2);
      do_txn(kind != 1, kind != 0, $urandom, $urandom, $urandom,
             32'd0, 32'd0, 32'd0, 1, 8'($urandom_range(0, 255)) & 8'hFE,
             1'($urandom_range(0, 1)));
    end
    idle_check("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
